// File: rtl/jk_latch_arbiter.sv
// Two-requester round-robin arbiter driving a bank of level-sensitive JK latch cells.
// Define JK_LATCH_READBACK_EN to check each cell's q against its expected value before ack.
module jk_latch_arbiter #(
  parameter int N = 4,
  parameter int IDX_W = 2,
  parameter int PULSE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [IDX_W-1:0] idx_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [IDX_W-1:0] idx_b,
  output logic             ack_b,
  output logic [N-1:0]     j,
  output logic [N-1:0]     k,
  output logic [N-1:0]     enable,
  input  logic [N-1:0]     q,
  output logic             busy,
  output logic             err
);

  localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE,
    ACK
  } state_t;

  function automatic logic bit_at(
    input logic [N-1:0] v,
    input logic [IDX_W-1:0] i
  );
    logic r;
    r = 1'b0;
    for (int n = 0; n < N; n++)
      if (i == IDX_W'(n)) r = v[n];
    return r;
  endfunction

  function automatic logic [N-1:0] dec(
    input logic [IDX_W-1:0] i
  );
    logic [N-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++)
      if (i == IDX_W'(n)) r[n] = 1'b1;
    return r;
  endfunction

  function automatic logic in_range(
    input logic [IDX_W-1:0] i
  );
    return {1'b0, i} < (IDX_W + 1)'(N);
  endfunction

  state_t           state, state_n;
  logic             last_b, last_n;
  logic             own_b, own_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [N-1:0]     j_n, k_n, en_n;
  logic             acka_n, ackb_n;
  logic             busy_n, err_n;

  logic             gnt_a, gnt_b;
  logic [1:0]       sel_op;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_q;
  logic             tj, tk;
  logic             mism;

`ifdef JK_LATCH_READBACK_EN
  logic [1:0] op_r, op_n;
  logic       qcap, qcap_n;
  logic       q_exp;

  always_comb begin
    q_exp = qcap;
    unique case (1'b1)
      op_r == 2'b01: q_exp = 1'b0;
      op_r == 2'b10: q_exp = 1'b1;
      op_r == 2'b11: q_exp = ~qcap;
      default: ;
    endcase
    mism = in_range(idx_r) & (bit_at(q, idx_r) != q_exp);
  end
`else
  assign mism = 1'b0;
`endif

  // last_b set means B was granted last, so A wins a tie.
  always_comb begin
    gnt_a   = req_a & (~req_b | last_b);
    gnt_b   = req_b & ~gnt_a;
    sel_op  = gnt_b ? op_b : op_a;
    sel_idx = gnt_b ? idx_b : idx_a;
    sel_q   = bit_at(q, sel_idx);
    tj      = 1'b0;
    tk      = 1'b0;
    unique case (1'b1)
      sel_op == 2'b01: tk = 1'b1;
      sel_op == 2'b10: tj = 1'b1;
      sel_op == 2'b11: begin
        tj = ~sel_q;
        tk = sel_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    last_n  = last_b;
    own_n   = own_b;
    idx_n   = idx_r;
    cnt_n   = cnt;
    j_n     = j;
    k_n     = k;
    en_n    = '0;
    acka_n  = 1'b0;
    ackb_n  = 1'b0;
    err_n   = 1'b0;
`ifdef JK_LATCH_READBACK_EN
    op_n    = op_r;
    qcap_n  = qcap;
`endif
    unique case (state)
      IDLE: begin
        j_n = '0;
        k_n = '0;
        if (gnt_a | gnt_b) begin
          own_n  = gnt_b;
          last_n = gnt_b;
          idx_n  = sel_idx;
          j_n    = dec(sel_idx) & {N{tj}};
          k_n    = dec(sel_idx) & {N{tk}};
`ifdef JK_LATCH_READBACK_EN
          op_n   = sel_op;
          qcap_n = sel_q;
`endif
          if (in_range(sel_idx) && sel_op != 2'b00) begin
            state_n = PULSE;
            en_n    = dec(sel_idx);
            cnt_n   = CW'(PULSE_CYC - 1);
          end else begin
            state_n = SETTLE;
          end
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = SETTLE;
        end else begin
          cnt_n = cnt - CW'(1);
          en_n  = dec(idx_r);
        end
      end
      SETTLE: begin
        state_n = ACK;
        acka_n  = ~own_b;
        ackb_n  = own_b;
        err_n   = ~in_range(idx_r) | mism;
        j_n     = '0;
        k_n     = '0;
      end
      ACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_b <= 1'b1;
      own_b  <= 1'b0;
      idx_r  <= '0;
      cnt    <= '0;
      j      <= '0;
      k      <= '0;
      enable <= '0;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
`ifdef JK_LATCH_READBACK_EN
      op_r   <= 2'b00;
      qcap   <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      last_b <= last_n;
      own_b  <= own_n;
      idx_r  <= idx_n;
      cnt    <= cnt_n;
      j      <= j_n;
      k      <= k_n;
      enable <= en_n;
      ack_a  <= acka_n;
      ack_b  <= ackb_n;
      busy   <= busy_n;
      err    <= err_n;
`ifdef JK_LATCH_READBACK_EN
      op_r   <= op_n;
      qcap   <= qcap_n;
`endif
    end
  end

endmodule

// File: tb/tb_jk_latch_arbiter.sv
// Bench for jk_latch_arbiter: vector table, corner sequences, random run vs model.
// Honours JK_LATCH_READBACK_EN for the frozen-q readback case.
module tb_jk_latch_arbiter;
  localparam int N = 3;
  localparam int IW = 2;
  localparam int P = 2;
`ifdef JK_LATCH_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic req_a, req_b, ack_a, ack_b;
  logic [1:0] op_a, op_b;
  logic [IW-1:0] idx_a, idx_b;
  logic [N-1:0] j, k, enable;
  logic [N-1:0] qm = '0;
  logic busy, err;
  logic qload = 1'b0;
  logic qfreeze = 1'b0;
  logic [N-1:0] qload_v = '0;

  int checks = 0;
  int errors = 0;

  jk_latch_arbiter #(.N(N), .IDX_W(IW), .PULSE_CYC(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .op_a(op_a), .idx_a(idx_a), .ack_a(ack_a),
    .req_b(req_b), .op_b(op_b), .idx_b(idx_b), .ack_b(ack_b),
    .j(j), .k(k), .enable(enable), .q(qm),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Cell bank: each enabled cycle applies the JK rule to the cell.
  always @(posedge clk) begin
    if (qload) qm <= qload_v;
    else if (!qfreeze)
      for (int i = 0; i < N; i++)
        if (enable[i]) begin
          if (j[i] && !k[i]) qm[i] <= 1'b1;
          else if (k[i] && !j[i]) qm[i] <= 1'b0;
          else if (j[i] && k[i]) qm[i] <= ~qm[i];
        end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input logic [IW-1:0] i);
    logic [N-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) if (int'(i) == n) r[n] = 1'b1;
    return r;
  endfunction

  function automatic logic qbit(input logic [IW-1:0] i);
    logic r;
    r = 1'b0;
    for (int n = 0; n < N; n++) if (int'(i) == n) r = qm[n];
    return r;
  endfunction

  typedef struct {
    bit b;
    logic [1:0] op;
    logic [IW-1:0] idx;
    bit qi;
    bit frz;
    int lat;
    int ens;
    logic [N-1:0] ej;
    logic [N-1:0] ek;
    bit eerr;
  } vec_t;

  vec_t vt[7];

  task automatic do_reset();
    req_a = 0; req_b = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int en_cnt, ack_c, bad_en, race, other, act;
    logic ebit;
    qload_v = qm;
    for (int i = 0; i < N; i++) if (int'(v.idx) == i) qload_v[i] = v.qi;
    qload = 1;
    @(posedge clk); #1;
    qload = 0;
    qfreeze = v.frz;
    if (v.b) begin req_b = 1; op_b = v.op; idx_b = v.idx; end
    else begin req_a = 1; op_a = v.op; idx_a = v.idx; end
    en_cnt = 0; ack_c = -1; bad_en = 0; race = 0; other = 0; act = 0;
    ebit = 0;
    for (int c = 0; c < 12 && ack_c < 0; c++) begin
      @(posedge clk); #1;
      if ((j & k) != 0) race++;
      if (v.b ? ack_a : ack_b) other++;
      if (v.ens == 0 && (enable | j | k) != 0) act++;
      if (enable != 0) begin
        en_cnt++;
        if (enable !== oh(v.idx) || j !== v.ej || k !== v.ek) bad_en++;
      end
      if (v.b ? ack_b : ack_a) begin ack_c = c; ebit = err; end
    end
    req_a = 0; req_b = 0;
    chk({nm, " ack latency"}, 32'(ack_c + 1), 32'(v.lat));
    chk({nm, " enable cycles"}, 32'(en_cnt), 32'(v.ens));
    chk({nm, " enable/j/k value"}, 32'(bad_en), 0);
    chk({nm, " j=k=1 race"}, 32'(race), 0);
    chk({nm, " wrong ack"}, 32'(other), 0);
    chk({nm, " err"}, 32'(ebit), 32'(v.eerr));
    chk({nm, " idle activity"}, 32'(act), 0);
    @(posedge clk); #1;
    qfreeze = 0;
    chk({nm, " ack one cycle"}, 32'({ack_a, ack_b}), 0);
    chk({nm, " busy after"}, 32'(busy), 0);
  endtask

  // Random-phase reference model state (transaction level).
  bit m_act, m_lastb, m_own, m_vld, m_pulse;
  logic [IW-1:0] m_idx;
  logic m_jt, m_kt;
  int m_t0, m_L, m_idle;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks[$];
    int both, multi, cyc;
    logic qb;
    logic [1:0] mop;
    logic [N-1:0] e_en, e_j, e_k;
    bit e_aa, e_ab, e_busy, e_err;

    vt[0] = '{0, 2'b10, 2, 0, 0, 4, 2, 3'b100, 3'b000, 0};
    vt[1] = '{1, 2'b11, 1, 1, 0, 4, 2, 3'b000, 3'b010, 0};
    vt[2] = '{0, 2'b11, 1, 0, 0, 4, 2, 3'b010, 3'b000, 0};
    vt[3] = '{1, 2'b01, 0, 1, 0, 4, 2, 3'b000, 3'b001, 0};
    vt[4] = '{0, 2'b00, 1, 0, 0, 2, 0, 3'b000, 3'b000, 0};
    vt[5] = '{0, 2'b10, 3, 0, 0, 2, 0, 3'b000, 3'b000, 1};
    vt[6] = '{0, 2'b10, 0, 0, 1, 4, 2, 3'b001, 3'b000, RB};

    op_a = 0; op_b = 0; idx_a = 0; idx_b = 0;
    do_reset();
    chk("reset enable", 32'(enable), 0);
    chk("reset j", 32'(j), 0);
    chk("reset k", 32'(k), 0);
    chk("reset acks", 32'({ack_a, ack_b}), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset err", 32'(err), 0);

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset during the second pulse cycle discards the command.
    req_a = 1; op_a = 2'b10; idx_a = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst in pulse", 32'(enable), 32'(oh(0)));
    rst_n = 0;
    @(posedge clk); #1;
    chk("midrst enable", 32'(enable), 0);
    chk("midrst jk", 32'({j, k}), 0);
    chk("midrst busy", 32'(busy), 0);
    req_a = 0; rst_n = 1;
    multi = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_a || ack_b || enable != 0) multi++;
    end
    chk("midrst no ack", 32'(multi), 0);
    run_vec(vt[1], "post-reset B");

    // Both requesting continuously: grants alternate from A.
    do_reset();
    req_a = 1; op_a = 2'b10; idx_a = 0;
    req_b = 1; op_b = 2'b01; idx_b = 1;
    both = 0; multi = 0;
    for (int c = 0; c < 40 && acks.size() < 4; c++) begin
      @(posedge clk); #1;
      if (ack_a && ack_b) both++;
      if (!$onehot0(enable)) multi++;
      if (ack_a) acks.push_back(0);
      if (ack_b) acks.push_back(1);
    end
    req_a = 0; req_b = 0;
    chk("fair ack count", 32'(acks.size()), 4);
    for (int i = 0; i < acks.size() && i < 4; i++)
      chk($sformatf("fair order %0d", i), 32'(acks[i]), 32'(i % 2));
    chk("fair ack overlap", 32'(both), 0);
    chk("fair onehot", 32'(multi), 0);
    repeat (3) @(posedge clk);

    // Random run against the transaction-level model.
    do_reset();
    m_act = 0; m_lastb = 1; m_idle = 0;
    m_own = 0; m_vld = 0; m_pulse = 0; m_idx = 0;
    m_jt = 0; m_kt = 0; m_t0 = 0; m_L = 2;
    for (cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      if (!m_act && cyc >= m_idle && (req_a || req_b)) begin
        m_own = req_b && !(req_a && m_lastb);
        m_lastb = m_own;
        m_idx = m_own ? idx_b : idx_a;
        mop = m_own ? op_b : op_a;
        qb = qbit(m_idx);
        m_vld = int'(m_idx) < N;
        m_pulse = m_vld && mop != 2'b00;
        m_jt = (mop == 2'b10) || (mop == 2'b11 && !qb);
        m_kt = (mop == 2'b01) || (mop == 2'b11 && qb);
        m_L = m_pulse ? P + 2 : 2;
        m_t0 = cyc;
        m_act = 1;
      end
      #1;
      e_en = '0; e_j = '0; e_k = '0;
      e_aa = 0; e_ab = 0; e_busy = 0; e_err = 0;
      if (m_act) begin
        if (m_pulse && cyc - m_t0 < P) e_en = oh(m_idx);
        if (m_pulse && cyc - m_t0 <= P) begin
          e_j = m_jt ? oh(m_idx) : '0;
          e_k = m_kt ? oh(m_idx) : '0;
        end
        e_busy = 1;
        if (cyc - m_t0 == m_L - 1) begin
          e_aa = !m_own; e_ab = m_own; e_err = !m_vld;
        end
      end
      if (enable !== e_en) chk("rand enable", 32'(enable), 32'(e_en));
      if (j !== e_j || k !== e_k)
        chk("rand jk", 32'({j, k}), 32'({e_j, e_k}));
      chk("rand ack/busy/err", 32'({ack_a, ack_b, busy, err}),
          32'({e_aa, e_ab, e_busy, e_err}));
      if (m_act && cyc - m_t0 == m_L - 1) begin
        m_act = 0;
        m_idle = cyc + 2;
      end
      if (ack_a) req_a = 0;
      else if (!req_a && $urandom_range(0, 2) == 0) begin
        req_a = 1;
        op_a = 2'($urandom_range(0, 3));
        idx_a = 2'($urandom_range(0, 3));
      end
      if (ack_b) req_b = 0;
      else if (!req_b && $urandom_range(0, 2) == 0) begin
        req_b = 1;
        op_b = 2'($urandom_range(0, 3));
        idx_b = 2'($urandom_range(0, 3));
      end
    end
    req_a = 0; req_b = 0;
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
